// File: rtl/down_counter_pkg.sv
// down_counter_pkg
//   Shared definitions for the down-counter timer and its subtractor.
//   - state_t  : two-state run/idle encoding, also used by the control FSMs
//                that consume this timer.
//   - is_zero  : width-generic zero compare. Narrower operands are
//                zero-extended at the call site, so the helper works for any
//                WIDTH up to 32.
package down_counter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;

  function automatic logic is_zero(input logic [MAX_WIDTH-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/subtractor.sv
// subtractor
//   Combinational a - bin with borrow-out. This is the down-direction
//   counterpart of the datapath adder.
//   Ports:
//     a      : minuend, WIDTH bits
//     bin    : borrow-in (subtracted as a single LSB)
//     diff   : (a - bin) modulo 2^WIDTH
//     borrow : high when the subtraction underflows (a == 0 and bin == 1)
module subtractor #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] w_ext;

  // The extra MSB of the widened difference is the borrow-out.
  assign w_ext  = {1'b0, a} - {{WIDTH{1'b0}}, bin};
  assign diff   = w_ext[WIDTH-1:0];
  assign borrow = w_ext[WIDTH];

endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Loadable, enable-gated down-counter used as a delay/timeout timer, with
//   optional auto-reload for periodic ticks.
//   Ports:
//     clk         : rising-edge clock
//     rst         : asynchronous active-low reset
//     start       : load `in` into count and reload register, begin a run
//                   (also restarts an active run)
//     stop        : synchronous abort; count holds, no done
//     en          : count enable
//     auto_reload : at terminal count reload and keep running
//     in          : load / reload value
//     count       : registered counter value
//     bo          : combinational borrow-out (RUN, en, count == 0)
//     busy        : high while in RUN
//     done        : one-cycle pulse following each terminal count
//     dbg_state   : current FSM state, for observation only
//
//   Handshake: a run loaded with N reaches its terminal cycle (bo high) on
//   the (N+1)th enabled RUN cycle; done is high during exactly the next
//   cycle. start outranks stop, which outranks counting.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             bo,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_terminal;

  subtractor #(.WIDTH(WIDTH)) u_sub (
    .a      (r_count),
    .bin    (en),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  // The subtractor only borrows when en is high and count is zero, which is
  // exactly the terminal condition while running.
  assign w_terminal = (r_state == ST_RUN) && w_borrow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_count  <= in;
            r_reload <= in;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (start) begin
            r_count  <= in;
            r_reload <= in;
          end else if (stop) begin
            r_state <= ST_IDLE;
          end else if (w_terminal) begin
            r_done <= 1'b1;
            if (auto_reload) begin
              r_count <= r_reload;
            end else begin
              // Count stays at zero rather than wrapping to all-ones.
              r_state <= ST_IDLE;
            end
          end else if (en) begin
            r_count <= w_diff;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign count     = r_count;
  assign bo        = w_terminal;
  assign busy      = (r_state == ST_RUN);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable, enable-gated down-counter with borrow-out and terminal-count handshake.
- Mirrors the existing loadable up-counter with carry-out: counts toward zero and flags underflow.
- Used as a programmable delay/timeout timer by the control FSMs in the same datapath.
- Optional auto-reload turns it into a periodic tick generator.

Parameters:
- WIDTH, 3, counter and load-value width in bits.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  load `in` into the counter and reload register; begin a run.
- stop  input  1  synchronous abort of a run.
- en  input  1  count enable; decrements only when high.
- auto_reload  input  1  at terminal count, reload and keep running instead of stopping.
- in  input  WIDTH  load / reload value.
- count  output  WIDTH  current counter value (registered).
- bo  output  1  borrow-out, combinational: high when state==RUN, en==1 and count==0.
- busy  output  1  high while state==RUN (registered state decode).
- done  output  1  one-cycle registered pulse after each terminal count.

Behaviour:
- Reset (rst==0, asynchronous): count=0, reload_reg=0, state=IDLE, busy=0, done=0. bo=0 because state is IDLE.
- Reset released mid-run: the block always resumes in IDLE; no run resumes.
- States: IDLE, RUN. Encoding comes from the shared package.
- IDLE:
  - start==1: count<=in, reload_reg<=in, state->RUN on the next edge.
  - Otherwise count holds and en is ignored.
- RUN, priority order per cycle:
  1. start==1: restart. count<=in, reload_reg<=in, stay in RUN, no done.
  2. stop==1: state->IDLE, count holds its current value, no done.
  3. en==1 and count!=0: count<=count-1.
  4. en==1 and count==0 (terminal, bo==1):
     - auto_reload==1: count<=reload_reg, stay in RUN.
     - auto_reload==0: count stays 0 (no wrap to all-ones), state->IDLE.
     - In both cases done<=1 on this edge, so the pulse is visible for exactly the following cycle.
  5. en==0: hold.
- Latency: a run loaded with value N takes N+1 enabled cycles to the terminal event. The bo cycle is the (N+1)th enabled cycle.
- in==0 at start: valid. The first enabled RUN cycle is terminal.
- Auto-reload period: N+1 enabled cycles, with done pulsing once per period.
- Simultaneous events:
  - start overrides stop, en and terminal count; done is not asserted.
  - stop at a terminal cycle suppresses done and bo's consequences, but bo is still combinationally high that cycle.
- done defaults to 0 on every cycle in which no terminal event occurred on the previous edge.
- Arithmetic is modulo 2^WIDTH internally. The decrement path is never taken at count==0.

Decomposition:
- Package down_counter_pkg:
  - state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1.
  - A width-generic zero-compare helper constant/function.
- Sub-module subtractor #(WIDTH):
  - Combinational count - bin, with a borrow output.
  - It is the down-direction counterpart of the existing adder.
  - The top instantiates it with bin=en and uses its borrow as the raw underflow indication.
- The next-state/count mux and the done register live in the top.

Test Plan (WIDTH=3):
- Reset: drive rst=0 mid-run with count=5 -> count=0, busy=0, done=0, bo=0 immediately (asynchronous); after release the block stays in IDLE until start.
- One-shot: start with in=3, auto_reload=0, en=1 continuously -> count 3,2,1,0. bo high on the 4th RUN cycle, done high the next cycle only, busy drops with it, count holds 0.
- Enable gating and wrap guard: in=2, en pattern 1,0,0,1,1 -> count 2,1,1,1,0 then terminal on the 5th cycle. count never shows 7.
- Auto-reload: in=1, auto_reload=1, en=1 for 8 cycles -> count 1,0,1,0,... done pulses every 2 cycles, busy stays high throughout.
- Restart and abort: RUN at count=4, start with in=6 -> count=6 and no done. Later stop at count=2 -> IDLE, count holds 2, no done.
- Edge cases:
  - in=0, auto_reload=0, en=1 -> bo on the first RUN cycle, done on the next.
  - start and stop asserted together in RUN -> restart wins.
